// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC stream scheduler.
package dac_sched_pkg;

    localparam int SAMPLE_W              = 8;
    localparam int DEFAULT_CLK_DIV       = 1042;
    localparam int DEFAULT_SILENCE_TICKS = 16;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        STREAM,
        RELEASE
    } state_e;

endpackage

// File: rtl/dac_stream_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// It picks the first requester strictly after the pointer, wrapping around.
module rr_arbiter #(
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] ptr,
    output logic [NUM_SRC-1:0]         grant,
    output logic [$clog2(NUM_SRC)-1:0] grant_idx,
    output logic                       grant_any
);

    localparam int PTR_W = $clog2(NUM_SRC);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int off = 1; off <= NUM_SRC; off++) begin
            idx = (int'(ptr) + off) % NUM_SRC;
            if (!grant_any && req[idx]) begin
                grant_any      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/dac_stream_scheduler.sv
// Shares one 8-bit delta-sigma DAC between NUM_SRC sources.
// Each sample tick it pulls one sample from the round-robin owner.
module dac_stream_scheduler
    import dac_sched_pkg::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int CLK_DIV       = DEFAULT_CLK_DIV,
    parameter int SILENCE_TICKS = DEFAULT_SILENCE_TICKS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SRC-1:0]           src_req,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [SAMPLE_W*NUM_SRC-1:0]  src_sample,
    output logic [NUM_SRC-1:0]           src_ready,
    output logic [NUM_SRC-1:0]           src_grant,
    output logic [SAMPLE_W-1:0]          dac_sample,
    output logic                         dac_silent,
    output logic                         tick,
    output logic                         underrun
);

    localparam int PTR_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int UF_W  = $clog2(SILENCE_TICKS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [UF_W-1:0]  UF_LIMIT = UF_W'(SILENCE_TICKS);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [UF_W-1:0]       uf_cnt_q, uf_cnt_d;
    logic [NUM_SRC-1:0]    grant_q, grant_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic                  silent_q, silent_d;

    logic [NUM_SRC-1:0]    win_onehot;
    logic [PTR_W-1:0]      win_idx;
    logic                  win_any;

    logic                  tick_w;
    logic                  owned;
    logic                  owner_req;
    logic                  owner_valid;
    logic [SAMPLE_W-1:0]   owner_sample;
    logic                  accept;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .req       (src_req),
        .ptr       (ptr_q),
        .grant     (win_onehot),
        .grant_idx (win_idx),
        .grant_any (win_any)
    );

    // ptr_q doubles as the owner index whenever a grant is held.
    always_comb begin
        tick_w       = !reset && (cnt_q == CNT_LAST);
        cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        owned        = (state_q == GRANT) || (state_q == STREAM);
        owner_req    = src_req[ptr_q];
        owner_valid  = src_valid[ptr_q];
        owner_sample = src_sample[int'(ptr_q)*SAMPLE_W +: SAMPLE_W];
        accept       = tick_w && owned && owner_req && owner_valid;
        src_ready    = accept ? grant_q : '0;
        underrun     = tick_w && (state_q == STREAM) && owner_req && !owner_valid;
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        uf_cnt_d = uf_cnt_q;
        grant_d  = grant_q;
        sample_d = sample_q;
        silent_d = silent_q;

        case (state_q)
            IDLE: begin
                grant_d  = '0;
                silent_d = 1'b1;
                sample_d = '0;
                if (win_any) begin
                    grant_d  = win_onehot;
                    ptr_d    = win_idx;
                    uf_cnt_d = '0;
                    state_d  = GRANT;
                end
            end
            GRANT, STREAM: begin
                if (tick_w) begin
                    if (!owner_req) begin
                        grant_d  = '0;
                        silent_d = 1'b1;
                        sample_d = '0;
                        state_d  = RELEASE;
                    end else if (owner_valid) begin
                        sample_d = owner_sample;
                        silent_d = 1'b0;
                        uf_cnt_d = '0;
                        state_d  = STREAM;
                    end else if (state_q == STREAM) begin
                        if (uf_cnt_q != UF_LIMIT) begin
                            uf_cnt_d = uf_cnt_q + 1'b1;
                        end
                        if (uf_cnt_d == UF_LIMIT) begin
                            silent_d = 1'b1;
                        end
                    end
                end
            end
            RELEASE: begin
                if (tick_w) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= PTR_W'(NUM_SRC - 1);
            uf_cnt_q <= '0;
            grant_q  <= '0;
            sample_q <= '0;
            silent_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            uf_cnt_q <= uf_cnt_d;
            grant_q  <= grant_d;
            sample_q <= sample_d;
            silent_q <= silent_d;
        end
    end

    assign tick       = tick_w;
    assign src_grant  = grant_q;
    assign dac_sample = sample_q;
    assign dac_silent = silent_q;

endmodule

// File: tb/tb_dac_stream_scheduler.sv
// Directed self-checking bench for dac_stream_scheduler (CLK_DIV=4, SILENCE_TICKS=2, NUM_SRC=2).
module tb_dac_stream_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  src_req;
    logic [1:0]  src_valid;
    logic [15:0] src_sample;
    logic [1:0]  src_ready;
    logic [1:0]  src_grant;
    logic [7:0]  dac_sample;
    logic        dac_silent;
    logic        tick;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    dac_stream_scheduler #(
        .NUM_SRC       (2),
        .CLK_DIV       (4),
        .SILENCE_TICKS (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .src_req    (src_req),
        .src_valid  (src_valid),
        .src_sample (src_sample),
        .src_ready  (src_ready),
        .src_grant  (src_grant),
        .dac_sample (dac_sample),
        .dac_silent (dac_silent),
        .tick       (tick),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advances to the next observation point where tick is high, bounded.
    task automatic wait_tick();
        int n;
        n = 0;
        step();
        while (tick !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_tick: tick=%b required 1 within 8 cycles", tick);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        src_req    = 2'b00;
        src_valid  = 2'b00;
        src_sample = 16'h0000;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] got, exp;
        reset      = 1'b1;
        src_req    = 2'b00;
        src_valid  = 2'b00;
        src_sample = 16'h0000;
        step();
        step();
        got = {tick, dac_silent, dac_sample, src_grant, src_ready};
        exp = {1'b0, 1'b1, 8'h00, 2'b00, 2'b00};
        checks++;
        if (got !== exp || underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h uf=%b required %h uf=0", got, underrun, exp);
        end
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            got = {tick, dac_silent, dac_sample, src_grant, src_ready};
            exp = {(i % 4 == 3), 1'b1, 8'h00, 2'b00, 2'b00};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL idle_cycle_%0d: got %h required %h", i, got, exp);
            end
        end
    endtask

    task automatic test_stream();
        do_reset();
        src_req    = 2'b01;
        src_valid  = 2'b01;
        src_sample = 16'h0010;
        step();
        checks++;
        if (src_grant !== 2'b01 || dac_silent !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stream_grant: grant=%b silent=%b required 01/1", src_grant, dac_silent);
        end
        wait_tick();
        checks++;
        if (src_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL stream_ready1: got %b required 01", src_ready);
        end
        step();
        checks++;
        if (dac_sample !== 8'h10 || dac_silent !== 1'b0 || src_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL stream_sample1: sample=%h silent=%b ready=%b required 10/0/00",
                     dac_sample, dac_silent, src_ready);
        end
        src_sample = 16'h0020;
        wait_tick();
        checks++;
        if (src_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL stream_ready2: got %b required 01", src_ready);
        end
        step();
        checks++;
        if (dac_sample !== 8'h20 || dac_silent !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_sample2: sample=%h silent=%b required 20/0", dac_sample, dac_silent);
        end
    endtask

    task automatic test_underrun();
        do_reset();
        src_req    = 2'b01;
        src_valid  = 2'b01;
        src_sample = 16'h0030;
        wait_tick();
        step();
        src_valid = 2'b00;
        wait_tick();
        checks++;
        if (underrun !== 1'b1 || src_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL underrun1: uf=%b ready=%b required 1/00", underrun, src_ready);
        end
        step();
        checks++;
        if (dac_sample !== 8'h30 || dac_silent !== 1'b0 || underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underrun1_hold: sample=%h silent=%b uf=%b required 30/0/0",
                     dac_sample, dac_silent, underrun);
        end
        wait_tick();
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underrun2: got %b required 1", underrun);
        end
        step();
        checks++;
        if (dac_sample !== 8'h30 || dac_silent !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underrun2_mute: sample=%h silent=%b required 30/1", dac_sample, dac_silent);
        end
        src_valid  = 2'b01;
        src_sample = 16'h007F;
        wait_tick();
        checks++;
        if (src_ready !== 2'b01 || underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL recover_ready: ready=%b uf=%b required 01/0", src_ready, underrun);
        end
        step();
        checks++;
        if (dac_sample !== 8'h7F || dac_silent !== 1'b0) begin
            errors++;
            $display("[TB] FAIL recover_sample: sample=%h silent=%b required 7f/0", dac_sample, dac_silent);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        src_req   = 2'b11;
        src_valid = 2'b00;
        step();
        checks++;
        if (src_grant !== 2'b01) begin
            errors++;
            $display("[TB] FAIL arb_first: grant=%b required 01", src_grant);
        end
        src_req = 2'b10;
        wait_tick();
        step();
        checks++;
        if (src_grant !== 2'b00 || dac_silent !== 1'b1) begin
            errors++;
            $display("[TB] FAIL arb_release0: grant=%b silent=%b required 00/1", src_grant, dac_silent);
        end
        src_req = 2'b11;
        wait_tick();
        step();
        checks++;
        if (src_grant !== 2'b00 || dac_silent !== 1'b1) begin
            errors++;
            $display("[TB] FAIL arb_guard_gap: grant=%b silent=%b required 00/1", src_grant, dac_silent);
        end
        step();
        checks++;
        if (src_grant !== 2'b10) begin
            errors++;
            $display("[TB] FAIL arb_second: grant=%b required 10", src_grant);
        end
        wait_tick();
        step();
        checks++;
        if (src_grant !== 2'b10) begin
            errors++;
            $display("[TB] FAIL arb_no_preempt: grant=%b required 10", src_grant);
        end
        src_req = 2'b01;
        wait_tick();
        step();
        src_req = 2'b11;
        wait_tick();
        step();
        step();
        checks++;
        if (src_grant !== 2'b01) begin
            errors++;
            $display("[TB] FAIL arb_third: grant=%b required 01", src_grant);
        end
    endtask

    task automatic test_drop_on_tick();
        do_reset();
        src_req    = 2'b01;
        src_valid  = 2'b01;
        src_sample = 16'h0055;
        wait_tick();
        step();
        wait_tick();
        src_req = 2'b00;
        #1;
        checks++;
        if (src_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL drop_ready: got %b required 00", src_ready);
        end
        step();
        checks++;
        if (dac_silent !== 1'b1 || dac_sample !== 8'h00 || src_grant !== 2'b00) begin
            errors++;
            $display("[TB] FAIL drop_release: silent=%b sample=%h grant=%b required 1/00/00",
                     dac_silent, dac_sample, src_grant);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] tick_seen;
        do_reset();
        src_req    = 2'b01;
        src_valid  = 2'b01;
        src_sample = 16'h0066;
        wait_tick();
        step();
        wait_tick();
        reset = 1'b1;
        #1;
        checks++;
        if (src_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL midreset_ready: got %b required 00", src_ready);
        end
        step();
        checks++;
        if (src_grant !== 2'b00 || dac_silent !== 1'b1 || dac_sample !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_state: grant=%b silent=%b sample=%h required 00/1/00",
                     src_grant, dac_silent, dac_sample);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tick_seen[i] = tick;
        end
        checks++;
        if (tick_seen !== 3'b100) begin
            errors++;
            $display("[TB] FAIL midreset_divider: ticks=%b required 100", tick_seen);
        end
    endtask

    initial begin
        reset      = 1'b1;
        src_req    = 2'b00;
        src_valid  = 2'b00;
        src_sample = 16'h0000;
        test_reset();
        test_stream();
        test_underrun();
        test_arbitration();
        test_drop_on_tick();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
